// File: rtl/router_output_arbiter_if.sv
// Output-port arbitration bus: input FIFO heads in, pop strobes and forwarded flit out.
interface router_output_arbiter_if #(
    parameter int unsigned NumPorts = 5,
    parameter int unsigned Width    = 66
);
    localparam int unsigned OwnerW = (NumPorts > 1) ? $clog2(NumPorts) : 1;

    logic [NumPorts-1:0]            in_empty;
    logic [NumPorts-1:0][Width-1:0] in_data;
    logic [NumPorts-1:0]            in_req;
    logic                           out_full;
    logic [NumPorts-1:0]            in_rdreq;
    logic                           out_wrreq;
    logic [Width-1:0]               out_data;
    logic                           locked;
    logic [OwnerW-1:0]              owner;
    logic                           proto_err;

    // Environment side: FIFOs and downstream flow control.
    modport master (
        output in_empty, in_data, in_req, out_full,
        input  in_rdreq, out_wrreq, out_data, locked, owner, proto_err
    );

    // Arbiter side.
    modport slave (
        input  in_empty, in_data, in_req, out_full,
        output in_rdreq, out_wrreq, out_data, locked, owner, proto_err
    );
endinterface

// File: rtl/router_output_arbiter.sv
// Round-robin wormhole arbiter for one router output: a header locks the output to
// its input until the tail passes; single-flit packets never lock.
module router_output_arbiter #(
    parameter int unsigned NumPorts = 5,
    parameter int unsigned Width    = 66
) (
    input  logic                   clk,
    input  logic                   rst,
    router_output_arbiter_if.slave bus
);
    localparam int unsigned OwnerW     = (NumPorts > 1) ? $clog2(NumPorts) : 1;
    localparam logic [1:0]  TypeHeader = 2'b10;
    localparam logic [1:0]  TypeBody   = 2'b00;
    localparam logic [1:0]  TypeTail   = 2'b01;
    localparam logic [1:0]  TypeSingle = 2'b11;

    typedef enum logic {
        IDLE   = 1'b0,
        LOCKED = 1'b1
    } state_t;

    state_t              state_q;
    state_t              state_d;
    logic [OwnerW-1:0]   ptr_q;
    logic [OwnerW-1:0]   ptr_d;
    logic [OwnerW-1:0]   owner_q;
    logic [OwnerW-1:0]   owner_d;

    logic [NumPorts-1:0] eligible;
    logic                grant_found;
    logic [OwnerW-1:0]   grant_idx;
    logic [OwnerW-1:0]   cand;
    logic [1:0]          grant_type;
    logic [1:0]          owner_type;

    logic [NumPorts-1:0] rdreq_c;
    logic                wrreq_c;
    logic [Width-1:0]    data_c;
    logic                perr_c;

    // Modulo-NumPorts increment used to advance the round-robin pointer.
    function automatic logic [OwnerW-1:0] wrap_inc(input logic [OwnerW-1:0] idx);
        if (32'(idx) == NumPorts - 1) begin
            return '0;
        end
        return idx + OwnerW'(1);
    endfunction

    // An input may open a packet only with a requesting, non-empty header or single flit.
    always_comb begin
        eligible = '0;
        for (int i = 0; i < int'(NumPorts); i++) begin
            eligible[i] = ~bus.in_empty[i] & bus.in_req[i] & bus.in_data[i][Width-1];
        end
    end

    // First eligible input at or after ptr, with wrap-around.
    always_comb begin
        grant_found = 1'b0;
        grant_idx   = '0;
        cand        = '0;
        for (int k = 0; k < int'(NumPorts); k++) begin
            cand = OwnerW'((32'(ptr_q) + 32'(k)) % NumPorts);
            if (!grant_found && eligible[cand]) begin
                grant_found = 1'b1;
                grant_idx   = cand;
            end
        end
    end

    assign grant_type = bus.in_data[grant_idx][Width-1 -: 2];
    assign owner_type = bus.in_data[owner_q][Width-1 -: 2];

    // Next state and zero-latency transfer strobes; reset suppresses every transfer.
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        owner_d = owner_q;
        rdreq_c = '0;
        wrreq_c = 1'b0;
        data_c  = '0;
        perr_c  = 1'b0;
        if (!rst && !bus.out_full) begin
            unique case (state_q)
                IDLE: begin
                    if (grant_found) begin
                        rdreq_c[grant_idx] = 1'b1;
                        wrreq_c            = 1'b1;
                        data_c             = bus.in_data[grant_idx];
                        owner_d            = grant_idx;
                        if (grant_type == TypeSingle) begin
                            ptr_d = wrap_inc(grant_idx);
                        end else begin
                            state_d = LOCKED;
                        end
                    end
                end
                LOCKED: begin
                    if (!bus.in_empty[owner_q]) begin
                        rdreq_c[owner_q] = 1'b1;
                        wrreq_c          = 1'b1;
                        data_c           = bus.in_data[owner_q];
                        unique case (owner_type)
                            TypeTail: begin
                                state_d = IDLE;
                                ptr_d   = wrap_inc(owner_q);
                            end
                            TypeBody: begin
                                state_d = LOCKED;
                            end
                            TypeHeader, TypeSingle: begin
                                // A new packet start inside a packet is passed on as body.
                                perr_c = 1'b1;
                            end
                            default: begin
                                state_d = LOCKED;
                            end
                        endcase
                    end
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    // State, round-robin pointer and owner registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            owner_q <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            owner_q <= owner_d;
        end
    end

    assign bus.in_rdreq  = rdreq_c;
    assign bus.out_wrreq = wrreq_c;
    assign bus.out_data  = data_c;
    assign bus.proto_err = perr_c;
    assign bus.locked    = (state_q == LOCKED);
    assign bus.owner     = owner_q;
endmodule

// File: tb/tb_router_output_arbiter.sv
// Scoreboard bench for router_output_arbiter: a packet-level model predicts transfers,
// a monitor compares what the arbiter actually forwards.
module tb_router_output_arbiter;
    localparam int unsigned N  = 5;
    localparam int unsigned W  = 66;
    localparam int unsigned OW = $clog2(N);
    localparam logic [1:0] T_HDR  = 2'b10;
    localparam logic [1:0] T_BODY = 2'b00;
    localparam logic [1:0] T_TAIL = 2'b01;
    localparam logic [1:0] T_SGL  = 2'b11;

    typedef struct packed {
        logic [OW-1:0] port;
        logic [W-1:0]  data;
        logic          perr;
    } xfer_t;

    typedef struct packed {
        logic          locked;
        logic [OW-1:0] owner;
    } stat_t;

    logic clk = 1'b0;
    logic rst;

    router_output_arbiter_if #(.NumPorts(N), .Width(W)) bus();
    router_output_arbiter #(.NumPorts(N), .Width(W)) dut (.clk(clk), .rst(rst), .bus(bus));

    always #5 clk = ~clk;

    logic [W-1:0] src_q [N][$];
    xfer_t        exp_xfer [$];
    stat_t        exp_stat [$];
    int           grant_log [$];
    int           want [$];
    int           perr_seen;
    int           checks;
    int           errors;

    // Packet-level model state: who holds the output and where the next search starts.
    bit m_locked;
    int m_ptr;
    int m_owner;

    function automatic void check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endfunction

    function automatic logic [W-1:0] make_flit(input logic [1:0] t);
        return {t, $urandom, $urandom};
    endfunction

    function automatic logic [1:0] ftype(input logic [W-1:0] d);
        return d[W-1:W-2];
    endfunction

    task automatic load(input int p, input string s);
        for (int i = 0; i < s.len(); i++) begin
            case (s[i])
                "H":     src_q[p].push_back(make_flit(T_HDR));
                "B":     src_q[p].push_back(make_flit(T_BODY));
                "T":     src_q[p].push_back(make_flit(T_TAIL));
                default: src_q[p].push_back(make_flit(T_SGL));
            endcase
        end
    endtask

    task automatic flush_all();
        for (int i = 0; i < N; i++) src_q[i].delete();
    endtask

    task automatic check_log(input string name);
        bit ok;
        ok = (grant_log.size() == want.size());
        for (int i = 0; i < want.size() && ok; i++) ok = (grant_log[i] == want[i]);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL %s: grants got %p expected %p", name, grant_log, want);
        end
    endtask

    // One clock: present FIFO heads, predict the response, consume per the model, go idle.
    task automatic step(input bit r, input bit full, input logic [N-1:0] hide, input bit rand_req);
        logic [N-1:0]        emp;
        logic [N-1:0]        req;
        logic [N-1:0][W-1:0] dat;
        logic [1:0]          t;
        int                  w;
        int                  p;
        stat_t               s;
        xfer_t               x;
        for (int i = 0; i < N; i++) begin
            emp[i] = (src_q[i].size() == 0) || hide[i];
            dat[i] = emp[i] ? W'({$urandom, $urandom, $urandom}) : src_q[i][0];
            req[i] = rand_req ? ($urandom_range(0, 3) != 0) : 1'b1;
        end
        rst          = r;
        bus.out_full = full;
        bus.in_empty = emp;
        bus.in_data  = dat;
        bus.in_req   = req;

        s.locked = m_locked;
        s.owner  = OW'(m_owner);
        exp_stat.push_back(s);

        w = -1;
        if (!r && !full) begin
            if (m_locked) begin
                if (!emp[m_owner]) w = m_owner;
            end else begin
                for (int k = 0; k < N; k++) begin
                    p = (m_ptr + k) % N;
                    t = ftype(dat[p]);
                    if (w < 0 && !emp[p] && req[p] && (t == T_HDR || t == T_SGL)) w = p;
                end
            end
        end

        if (w >= 0) begin
            t      = ftype(dat[w]);
            x.port = OW'(w);
            x.data = dat[w];
            x.perr = m_locked && (t == T_HDR || t == T_SGL);
            exp_xfer.push_back(x);
            void'(src_q[w].pop_front());
            if (!m_locked) begin
                m_owner = w;
                if (t == T_SGL) m_ptr = (w + 1) % N;
                else            m_locked = 1'b1;
            end else if (t == T_TAIL) begin
                m_locked = 1'b0;
                m_ptr    = (m_owner + 1) % N;
            end
        end
        if (r) begin
            m_locked = 1'b0;
            m_ptr    = 0;
            m_owner  = 0;
        end

        @(posedge clk);
        #1;
        rst          = 1'b0;
        bus.out_full = 1'b0;
        bus.in_empty = '1;
        bus.in_req   = '0;
        @(negedge clk);
    endtask

    task automatic reset_step();
        step(1'b1, 1'b0, '0, 1'b0);
        grant_log.delete();
        perr_seen = 0;
    endtask

    // Monitor: invariants every cycle, status per cycle, transfers in order.
    initial begin
        int    idx;
        xfer_t x;
        stat_t s;
        forever begin
            @(negedge clk);
            #2;
            checks++;
            if (!$onehot0(bus.in_rdreq)) begin
                errors++;
                $display("FAIL rdreq_onehot: got %b", bus.in_rdreq);
            end
            checks++;
            if ((bus.in_rdreq & bus.in_empty) != '0) begin
                errors++;
                $display("FAIL rdreq_on_empty: rdreq %b empty %b", bus.in_rdreq, bus.in_empty);
            end
            checks++;
            if (bus.out_wrreq && bus.out_full) begin
                errors++;
                $display("FAIL write_while_full: got wrreq=1 expected 0");
            end
            check("wrreq_is_or_rdreq", W'(bus.out_wrreq), W'(|bus.in_rdreq));
            if (exp_stat.size() > 0) begin
                s = exp_stat.pop_front();
                check("locked", W'(bus.locked), W'(s.locked));
                check("owner", W'(bus.owner), W'(s.owner));
            end
            if (bus.proto_err) perr_seen++;
            if (bus.out_wrreq) begin
                idx = -1;
                for (int i = 0; i < N; i++) if (bus.in_rdreq[i]) idx = i;
                grant_log.push_back(idx);
                if (exp_xfer.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_xfer: got port %0d expected none", idx);
                end else begin
                    x = exp_xfer.pop_front();
                    check("xfer_port", W'(idx), W'(x.port));
                    check("xfer_data", bus.out_data, x.data);
                    check("proto_err", W'(bus.proto_err), W'(x.perr));
                end
            end else begin
                check("idle_data_zero", bus.out_data, '0);
                check("idle_proto_err", W'(bus.proto_err), '0);
            end
        end
    end

    initial begin
        logic [N-1:0] hide;
        int           nb;
        checks       = 0;
        errors       = 0;
        perr_seen    = 0;
        m_locked     = 1'b0;
        m_ptr        = 0;
        m_owner      = 0;
        rst          = 1'b1;
        bus.out_full = 1'b0;
        bus.in_empty = '1;
        bus.in_data  = '0;
        bus.in_req   = '0;
        repeat (2) @(negedge clk);

        // Reset state, then two headers: port 1 wins from ptr 0, port 3 after the tail.
        reset_step();
        load(1, "HBBT");
        load(3, "HT");
        repeat (7) step(1'b0, 1'b0, '0, 1'b0);
        want = '{1, 1, 1, 1, 3, 3};
        check_log("hdr_lock_then_rr");

        // Continuous single flits rotate through every port without locking.
        reset_step();
        for (int i = 0; i < N; i++) load(i, "SS");
        repeat (10) step(1'b0, 1'b0, '0, 1'b0);
        want = '{0, 1, 2, 3, 4, 0, 1, 2, 3, 4};
        check_log("single_flit_rotation");

        // Downstream full stalls a locked packet, flit moves once space returns.
        reset_step();
        load(2, "HBBT");
        step(1'b0, 1'b0, '0, 1'b0);
        repeat (3) step(1'b0, 1'b1, '0, 1'b0);
        want = '{2};
        check_log("full_stall");
        step(1'b0, 1'b0, '0, 1'b0);
        want = '{2, 2};
        check_log("full_release");
        repeat (3) step(1'b0, 1'b0, '0, 1'b0);

        // Owner runs dry while port 4 waits with a header: the lock holds.
        reset_step();
        load(0, "HBT");
        load(4, "HT");
        step(1'b0, 1'b0, '0, 1'b0);
        repeat (3) step(1'b0, 1'b0, 5'b00001, 1'b0);
        want = '{0};
        check_log("owner_empty_hold");
        repeat (4) step(1'b0, 1'b0, '0, 1'b0);
        want = '{0, 0, 0, 4, 4};
        check_log("owner_empty_release");

        // Stray header inside a packet is forwarded and flagged once.
        reset_step();
        load(0, "HBHBT");
        repeat (6) step(1'b0, 1'b0, '0, 1'b0);
        want = '{0, 0, 0, 0, 0};
        check_log("stray_header_forwarded");
        check("stray_header_pulses", W'(perr_seen), W'(1));

        // Reset mid-packet drops the lock; ptr restarts at 0.
        reset_step();
        load(0, "HBBT");
        load(1, "HT");
        repeat (2) step(1'b0, 1'b0, '0, 1'b0);
        reset_step();
        src_q[0].delete();
        load(0, "HT");
        repeat (5) step(1'b0, 1'b0, '0, 1'b0);
        want = '{0, 0, 1, 1};
        check_log("reset_mid_packet");

        // Randomized traffic with backpressure, FIFO bubbles, flickering requests and resets.
        reset_step();
        for (int c = 0; c < 3000; c++) begin
            for (int i = 0; i < N; i++) begin
                if (src_q[i].size() < 2 && $urandom_range(0, 2) == 0) begin
                    if ($urandom_range(0, 9) < 4) begin
                        load(i, "S");
                    end else begin
                        load(i, "H");
                        nb = $urandom_range(0, 3);
                        for (int b = 0; b < nb; b++) load(i, ($urandom_range(0, 19) == 0) ? "H" : "B");
                        load(i, "T");
                    end
                end
            end
            for (int i = 0; i < N; i++) hide[i] = ($urandom_range(0, 9) == 0);
            if ($urandom_range(0, 399) == 0) begin
                step(1'b1, 1'b0, hide, 1'b1);
                flush_all();
            end else begin
                step(1'b0, ($urandom_range(0, 3) == 0), hide, 1'b1);
            end
        end

        repeat (2) @(negedge clk);
        check("xfer_queue_drained", W'(exp_xfer.size()), '0);
        check("stat_queue_drained", W'(exp_stat.size()), '0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/router_output_arbiter.md
ROUTER_OUTPUT_ARBITER -- requirements
Module: router_output_arbiter

Interface
REQ-001 Parameter NumPorts, default 5, number of input ports competing for this output.
REQ-002 Parameter Width, default 66, flit width; flit type is bits [Width-1:Width-2]: 2'b10 header, 2'b00 body, 2'b01 tail, 2'b11 single-flit packet.
REQ-003 clk  input  1  single clock; all logic is synchronous to its rising edge.
REQ-004 rst  input  1  reset, synchronous and active-high.
REQ-005 in_empty  input  NumPorts  empty flag of each input FIFO.
REQ-006 in_data  input  NumPorts x Width  head flit of each input FIFO.
REQ-007 in_req  input  NumPorts  input i's head header targets this output; valid only while that head is a header or single flit.
REQ-008 out_full  input  1  downstream FIFO full; no flit may be written while high.
REQ-009 in_rdreq  output  NumPorts  one-hot or zero pop strobe to the input FIFOs.
REQ-010 out_wrreq  output  1  push strobe to the downstream FIFO.
REQ-011 out_data  output  Width  flit forwarded; equals in_data[owner] when out_wrreq=1, else '0.
REQ-012 locked  output  1  high while a multi-flit packet holds the output.
REQ-013 owner  output  $clog2(NumPorts)  index of the current or last granted input.
REQ-014 proto_err  output  1  one-cycle pulse on a flit-sequence violation.

Function
REQ-015 Two states, IDLE and LOCKED, plus a round-robin pointer ptr in 0..NumPorts-1.
REQ-016 Eligibility in IDLE: ~in_empty[i] & in_req[i] & head type in {10,11}; inputs whose head is body or tail are never eligible in IDLE.
REQ-017 IDLE grant: if any input is eligible and out_full=0, select the first eligible index at or after ptr, with wrap-around, in the same cycle.
REQ-018 Transfer: in_rdreq[w]=1, out_wrreq=1, and out_data=in_data[w] in the same cycle as the grant (zero-cycle latency); owner<=w.
REQ-019 Header (10) granted in IDLE: go to LOCKED next cycle; ptr unchanged.
REQ-020 Single flit (11) granted in IDLE: stay in IDLE; ptr<=(w+1) mod NumPorts.
REQ-021 LOCKED: transfer occurs only when in_empty[owner]=0 and out_full=0; all other inputs receive in_rdreq=0 and in_req is ignored.
REQ-022 LOCKED, tail (01) transferred: return to IDLE next cycle; ptr<=(owner+1) mod NumPorts.
REQ-023 LOCKED, body (00) transferred: stay in LOCKED.
REQ-024 LOCKED, head of owner is 10 or 11: pulse proto_err and forward the flit as body; stay in LOCKED.
REQ-025 No flit ever transfers while out_full=1; in_rdreq and out_wrreq are both 0 that cycle, and state, ptr, and owner hold.
REQ-026 At most one in_rdreq bit is high per cycle; out_wrreq equals the OR of in_rdreq.
REQ-027 in_rdreq[i] is never asserted while in_empty[i]=1.
REQ-028 locked = (state==LOCKED); the output is combinational from state, ptr, owner, and inputs.
REQ-029 A flow-controlled stall of unbounded length in LOCKED keeps the lock; there is no timeout.

Reset
REQ-030 While rst=1: state<=IDLE, ptr<=0, owner<=0; the outputs in_rdreq, out_wrreq, out_data, and proto_err are forced to 0 that cycle.
REQ-031 Reset asserted mid-packet drops the lock immediately; the first cycle after reset behaves as IDLE with ptr=0.

Verification
REQ-032 Ports 1 and 3 present headers (type 10) with out_full=0 -> port 1 is granted and locked=1; bodies then a tail from port 1 follow -> return to IDLE and ptr=2; port 3 is granted next.
REQ-033 All 5 ports present single flits (11) continuously -> grants are 0,1,2,3,4,0 in consecutive cycles and locked stays 0.
REQ-034 Port 2 is locked, out_full=1 for 3 cycles while port 2 is non-empty -> in_rdreq=0 for 3 cycles; then out_full=0 -> the pending flit is transferred on the next cycle.
REQ-035 Port 0 is locked and in_empty[0]=1 while port 4 has an eligible header -> no transfer from port 4 until port 0's tail passes.
REQ-036 A header appears at port 0's head while port 0 holds LOCKED -> proto_err=1 for one cycle, the flit is forwarded, and locked stays 1.
REQ-037 rst=1 after a body transfer in LOCKED -> the next cycle has locked=0 and ptr=0, and a new header at port 0 is granted immediately.
REQ-038 Formal: the bench checks $onehot0(in_rdreq), !(in_rdreq[i] & in_empty[i]), and !(out_wrreq & out_full) on every cycle.
